// File: rtl/st_dma_bus_arbiter_if.sv
// Bus-arbitration signal bundle between the DMA arbiter, its requesters and the 68000 bus wrapper.
interface st_dma_bus_arbiter_if #(
  parameter int unsigned N = 2
);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [2:0]   owner;
  logic         busy;
  logic         br_n;
  logic         bg_n;
  logic         as_n;
  logic         bgack_n;

  modport master (
    input  req, bg_n, as_n,
    output gnt, owner, busy, br_n, bgack_n
  );

  modport slave (
    output req, bg_n, as_n,
    input  gnt, owner, busy, br_n, bgack_n
  );
endinterface

// File: rtl/st_dma_bus_arbiter.sv
// Round-robin arbiter handing the 68000 bus to on-chip DMA masters via BR/BG/BGACK,
// with a programmable CPU slot between DMA tenures.
module st_dma_bus_arbiter #(
  parameter int unsigned N              = 2,
  parameter int unsigned MIN_CPU_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  st_dma_bus_arbiter_if.master  bus
);

  localparam int unsigned CNT_W = (MIN_CPU_CYCLES > 1) ? $clog2(MIN_CPU_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((MIN_CPU_CYCLES > 0) ? (MIN_CPU_CYCLES - 1) : 0);
  localparam logic [2:0] LAST_RST = 3'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_BUS,
    S_OWN,
    S_CPU_SLOT
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_gnt;
  logic [2:0]       r_owner;
  logic [2:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br_n;
  logic             r_bgack_n;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [N-1:0]     w_gnt_nxt;
  logic [2:0]       w_owner_nxt;
  logic [2:0]       w_last_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_br_n_nxt;
  logic             w_bgack_n_nxt;

  logic [7:0]       w_req8;
  logic [7:0]       w_owner_oh8;
  logic             w_owner_req;
  logic [2:0]       w_rr_idx;
  logic [2:0]       w_win;
  logic             w_win_vld;

  assign w_req8      = 8'(bus.req);
  assign w_owner_req = w_req8[r_owner];
  assign w_owner_oh8 = 8'b1 << r_owner;

  // Round-robin search upward from the slot after the last owner.
  always_comb begin
    w_rr_idx  = '0;
    w_win     = r_last;
    w_win_vld = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_rr_idx = 3'((32'(r_last) + i) % N);
      if (!w_win_vld && w_req8[w_rr_idx]) begin
        w_win     = w_rr_idx;
        w_win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode; every decision uses one sampling edge.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_owner_nxt   = r_owner;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_br_n_nxt    = r_br_n;
    w_bgack_n_nxt = r_bgack_n;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_owner_nxt = w_win;
          w_br_n_nxt  = 1'b0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (!w_owner_req) begin
          w_br_n_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!bus.bg_n) begin
          w_state_nxt = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        if (!w_owner_req) begin
          w_br_n_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (bus.as_n) begin
          w_bgack_n_nxt = 1'b0;
          w_br_n_nxt    = 1'b1;
          w_gnt_nxt     = N'(w_owner_oh8);
          w_state_nxt   = S_OWN;
        end
      end
      S_OWN: begin
        if (!w_owner_req) begin
          w_gnt_nxt     = '0;
          w_bgack_n_nxt = 1'b1;
          w_last_nxt    = r_owner;
          if (MIN_CPU_CYCLES == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = S_CPU_SLOT;
          end
        end
      end
      S_CPU_SLOT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt     <= '0;
      r_owner   <= '0;
      r_last    <= LAST_RST;
      r_cnt     <= '0;
      r_br_n    <= 1'b1;
      r_bgack_n <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_owner   <= w_owner_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_br_n    <= w_br_n_nxt;
      r_bgack_n <= w_bgack_n_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.owner   = r_owner;
  assign bus.busy    = r_busy;
  assign bus.br_n    = r_br_n;
  assign bus.bgack_n = r_bgack_n;

endmodule
